// File: rtl/hazard_stall_ctrl.sv
// Decode-stage sequencing controller: load-use / RAW bubble insertion,
// data-memory wait hold, misprediction squash of IF/ID, stall statistics
// and memory-wait timeout detection.
module hazard_stall_ctrl #(
  parameter int unsigned FWD_EN   = 1,
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IFID_valid,
  input  logic [2:0]       IFID_Rs,
  input  logic [2:0]       IFID_Rt,
  input  logic             IFID_UsesRs,
  input  logic             IFID_UsesRt,
  input  logic             IDEX_RegWrt,
  input  logic             IDEX_MemRead,
  input  logic [2:0]       IDEX_RD,
  input  logic             EXMEM_RegWrt,
  input  logic [2:0]       EXMEM_RD,
  input  logic             DM_Req,
  input  logic             Done_DM,
  input  logic             misprediction,
  output logic             NOP_mech,
  output logic             PC_stall,
  output logic             IFID_stall,
  output logic             IDEX_stall,
  output logic             EXMEM_stall,
  output logic             IFID_flush,
  output logic             stall_err,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    S_INIT    = 2'd0,
    S_RUN     = 2'd1,
    S_MEMWAIT = 2'd2,
    S_ERR     = 2'd3
  } state_t;

  localparam int unsigned        WAIT_W    = $clog2(MAX_WAIT);
  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic match_idex;
  logic match_exmem;
  logic lu;
  logic raw;
  logic haz;
  logic mw;

  // Operand comparison and hazard classification for the instruction in decode.
  always_comb begin
    match_idex  = (IFID_UsesRs && (IFID_Rs == IDEX_RD)) ||
                  (IFID_UsesRt && (IFID_Rt == IDEX_RD));
    match_exmem = (IFID_UsesRs && (IFID_Rs == EXMEM_RD)) ||
                  (IFID_UsesRt && (IFID_Rt == EXMEM_RD));
    lu = IFID_valid && IDEX_RegWrt && IDEX_MemRead && match_idex;
    if (FWD_EN != 0) begin
      raw = 1'b0;
    end else begin
      raw = IFID_valid && ((IDEX_RegWrt && match_idex) ||
                           (EXMEM_RegWrt && match_exmem));
    end
    haz = lu || raw;
    mw  = DM_Req && !Done_DM;
  end

  // Next-state, wait counter and same-cycle stall/flush outputs.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    NOP_mech    = 1'b0;
    PC_stall    = 1'b0;
    IFID_stall  = 1'b0;
    IDEX_stall  = 1'b0;
    EXMEM_stall = 1'b0;
    IFID_flush  = 1'b0;
    unique case (state_q)
      S_INIT: begin
        NOP_mech = 1'b1;
        state_d  = S_RUN;
      end
      S_RUN, S_MEMWAIT: begin
        if (mw) begin
          PC_stall    = 1'b1;
          IFID_stall  = 1'b1;
          IDEX_stall  = 1'b1;
          EXMEM_stall = 1'b1;
          if (state_q == S_RUN) begin
            state_d    = S_MEMWAIT;
            wait_cnt_d = '0;
          end else if (wait_cnt_q == WAIT_LAST) begin
            state_d = S_ERR;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end else begin
          state_d = S_RUN;
          if (misprediction) begin
            IFID_flush = 1'b1;
          end else if (haz) begin
            NOP_mech   = 1'b1;
            PC_stall   = 1'b1;
            IFID_stall = 1'b1;
          end
        end
      end
      S_ERR: begin
        NOP_mech    = 1'b1;
        PC_stall    = 1'b1;
        IFID_stall  = 1'b1;
        IDEX_stall  = 1'b1;
        EXMEM_stall = 1'b1;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  // Saturating count of stalled-PC cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (PC_stall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_INIT;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Status outputs.
  always_comb begin
    stall_err = (state_q == S_ERR);
    stall_cnt = stall_cnt_q;
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench: two controller instances (forwarding / no forwarding,
// different timeout and counter widths) share one randomized input stream.
module tb_hazard_stall_ctrl;

  localparam int FWD_A = 1;
  localparam int MW_A  = 4;
  localparam int CW_A  = 4;
  localparam int FWD_B = 0;
  localparam int MW_B  = 6;
  localparam int CW_B  = 5;

  typedef struct packed {
    logic [6:0] ctl;  // {NOP, PC, IFID, IDEX, EXMEM, FLUSH, ERR}
    logic [7:0] cnt;
  } exp_t;

  logic clk;
  logic rst;
  logic IFID_valid;
  logic [2:0] IFID_Rs;
  logic [2:0] IFID_Rt;
  logic IFID_UsesRs;
  logic IFID_UsesRt;
  logic IDEX_RegWrt;
  logic IDEX_MemRead;
  logic [2:0] IDEX_RD;
  logic EXMEM_RegWrt;
  logic [2:0] EXMEM_RD;
  logic DM_Req;
  logic Done_DM;
  logic misprediction;

  logic nop_a, pcs_a, ifs_a, ids_a, exs_a, fl_a, err_a;
  logic nop_b, pcs_b, ifs_b, ids_b, exs_b, fl_b, err_b;
  logic [CW_A-1:0] cnt_a;
  logic [CW_B-1:0] cnt_b;

  hazard_stall_ctrl #(.FWD_EN(FWD_A), .MAX_WAIT(MW_A), .CNT_W(CW_A)) dut_a (
    .clk(clk), .rst(rst), .IFID_valid(IFID_valid), .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
    .IFID_UsesRs(IFID_UsesRs), .IFID_UsesRt(IFID_UsesRt), .IDEX_RegWrt(IDEX_RegWrt),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_RD(IDEX_RD), .EXMEM_RegWrt(EXMEM_RegWrt),
    .EXMEM_RD(EXMEM_RD), .DM_Req(DM_Req), .Done_DM(Done_DM), .misprediction(misprediction),
    .NOP_mech(nop_a), .PC_stall(pcs_a), .IFID_stall(ifs_a), .IDEX_stall(ids_a),
    .EXMEM_stall(exs_a), .IFID_flush(fl_a), .stall_err(err_a), .stall_cnt(cnt_a)
  );

  hazard_stall_ctrl #(.FWD_EN(FWD_B), .MAX_WAIT(MW_B), .CNT_W(CW_B)) dut_b (
    .clk(clk), .rst(rst), .IFID_valid(IFID_valid), .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
    .IFID_UsesRs(IFID_UsesRs), .IFID_UsesRt(IFID_UsesRt), .IDEX_RegWrt(IDEX_RegWrt),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_RD(IDEX_RD), .EXMEM_RegWrt(EXMEM_RegWrt),
    .EXMEM_RD(EXMEM_RD), .DM_Req(DM_Req), .Done_DM(Done_DM), .misprediction(misprediction),
    .NOP_mech(nop_b), .PC_stall(pcs_b), .IFID_stall(ifs_b), .IDEX_stall(ids_b),
    .EXMEM_stall(exs_b), .IFID_flush(fl_b), .stall_err(err_b), .stall_cnt(cnt_b)
  );

  logic [6:0] act_ctl [2];
  logic [7:0] act_cnt [2];
  always_comb begin
    act_ctl[0] = {nop_a, pcs_a, ifs_a, ids_a, exs_a, fl_a, err_a};
    act_ctl[1] = {nop_b, pcs_b, ifs_b, ids_b, exs_b, fl_b, err_b};
    act_cnt[0] = 8'(cnt_a);
    act_cnt[1] = 8'(cnt_b);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: plain counters per instance
  int p_fwd  [2] = '{FWD_A, FWD_B};
  int p_mw   [2] = '{MW_A, MW_B};
  int p_cmax [2] = '{(1 << CW_A) - 1, (1 << CW_B) - 1};
  int m_init [2];   // first cycle after reset release
  int m_err  [2];   // timeout latched
  int m_streak [2]; // consecutive memory-wait cycles
  int m_scnt [2];   // stalled-PC cycles, saturating

  exp_t qa[$];
  exp_t qb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit run_active = 0;

  function automatic bit uses_reg(input logic [2:0] rd);
    return (IFID_UsesRs && IFID_Rs == rd) || (IFID_UsesRt && IFID_Rt == rd);
  endfunction

  task automatic bump(input int i);
    if (m_scnt[i] < p_cmax[i]) m_scnt[i]++;
  endtask

  // Compute this cycle's expected outputs from the inputs now applied.
  task automatic step();
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      bit mw, lu, raw, haz;
      e.ctl = 7'b0000000;
      e.cnt = 8'(m_scnt[i]);
      if (!rst) begin
        e.ctl = 7'b1000000;
        e.cnt = 8'd0;
        m_init[i] = 1; m_err[i] = 0; m_streak[i] = 0; m_scnt[i] = 0;
      end else if (m_init[i] != 0) begin
        e.ctl = 7'b1000000;
        m_init[i] = 0;
      end else if (m_err[i] != 0) begin
        e.ctl = 7'b1111101;
        bump(i);
      end else begin
        mw  = DM_Req && !Done_DM;
        lu  = IFID_valid && IDEX_RegWrt && IDEX_MemRead && uses_reg(IDEX_RD);
        raw = (p_fwd[i] == 0) && IFID_valid &&
              ((IDEX_RegWrt && uses_reg(IDEX_RD)) || (EXMEM_RegWrt && uses_reg(EXMEM_RD)));
        haz = lu || raw;
        if (mw) begin
          e.ctl = 7'b0111100;
          m_streak[i]++;
          if (m_streak[i] == p_mw[i] + 1) m_err[i] = 1;
          bump(i);
        end else begin
          m_streak[i] = 0;
          if (misprediction) begin
            e.ctl = 7'b0000010;
          end else if (haz) begin
            e.ctl = 7'b1110000;
            bump(i);
          end
        end
      end
      if (i == 0) qa.push_back(e); else qb.push_back(e);
    end
    run_active = 1;
  endtask

  task automatic check(input int i, input exp_t e);
    n_cmp++;
    if (act_ctl[i] !== e.ctl) begin
      n_bad++;
      $display("FAIL ctl_%0d cyc=%0d got=%b exp=%b (NOP,PC,IFID,IDEX,EXMEM,FLUSH,ERR)",
               i, cyc, act_ctl[i], e.ctl);
    end
    n_cmp++;
    if (act_cnt[i] !== e.cnt) begin
      n_bad++;
      $display("FAIL stall_cnt_%0d cyc=%0d got=%0d exp=%0d", i, cyc, act_cnt[i], e.cnt);
    end
  endtask

  // Monitor: outputs are presented every cycle; sample mid-cycle.
  always @(negedge clk) begin
    if (run_active) begin
      cyc++;
      if (qa.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb_empty_0 cyc=%0d got=0 entries exp>=1", cyc);
      end else begin
        check(0, qa.pop_front());
      end
      if (qb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb_empty_1 cyc=%0d got=0 entries exp>=1", cyc);
      end else begin
        check(1, qb.pop_front());
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    IFID_valid = 0; IFID_Rs = 0; IFID_Rt = 0; IFID_UsesRs = 0; IFID_UsesRt = 0;
    IDEX_RegWrt = 0; IDEX_MemRead = 0; IDEX_RD = 0; EXMEM_RegWrt = 0; EXMEM_RD = 0;
    DM_Req = 0; Done_DM = 0; misprediction = 0;
  endtask

  task automatic load_use_r3();
    IFID_valid = 1; IFID_Rs = 3; IFID_UsesRs = 1; IFID_Rt = 1; IFID_UsesRt = 1;
    IDEX_RegWrt = 1; IDEX_MemRead = 1; IDEX_RD = 3;
  endtask

  int burst;
  int rst_left;

  initial begin
    rst = 0;
    idle_inputs();
    for (int k = 0; k < 2; k++) begin next_cycle(); rst = 0; step(); end
    next_cycle(); rst = 1; step();                       // INIT cycle
    next_cycle(); idle_inputs(); load_use_r3(); step();  // bubble
    next_cycle(); idle_inputs(); step();                 // clear
    next_cycle(); idle_inputs();
    IFID_valid = 1; IFID_Rt = 5; IFID_UsesRt = 1; IFID_Rs = 2; IFID_UsesRs = 1;
    EXMEM_RegWrt = 1; EXMEM_RD = 5; step();              // RAW only without forwarding
    next_cycle(); IFID_UsesRt = 0; step();               // Rt not read: no stall
    for (int k = 0; k < 3; k++) begin
      next_cycle(); idle_inputs(); DM_Req = 1; Done_DM = 0; step();
    end
    next_cycle(); DM_Req = 1; Done_DM = 1; step();
    next_cycle(); idle_inputs(); DM_Req = 1; Done_DM = 1; step();
    next_cycle(); idle_inputs(); load_use_r3(); misprediction = 1; step();
    next_cycle(); idle_inputs(); DM_Req = 1; misprediction = 1; step();
    next_cycle(); idle_inputs(); step();
    for (int k = 0; k < 10; k++) begin                   // timeout on both instances
      next_cycle(); idle_inputs(); DM_Req = (k < 8); step();
    end
    next_cycle(); idle_inputs(); rst = 0; step();
    next_cycle(); rst = 1; step();
    for (int k = 0; k < 40; k++) begin                   // saturation
      next_cycle(); idle_inputs(); load_use_r3(); step();
    end

    burst = 0;
    rst_left = 0;
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      if (rst_left > 0) begin
        rst = 0; rst_left--;
      end else begin
        rst = 1;
        if ($urandom_range(0, 59) == 0) begin rst = 0; rst_left = $urandom_range(0, 1); end
      end
      IFID_valid    = ($urandom_range(0, 7) != 0);
      IFID_Rs       = 3'($urandom_range(0, 3));
      IFID_Rt       = 3'($urandom_range(0, 3));
      IFID_UsesRs   = 1'($urandom_range(0, 1));
      IFID_UsesRt   = 1'($urandom_range(0, 1));
      IDEX_RegWrt   = 1'($urandom_range(0, 1));
      IDEX_MemRead  = 1'($urandom_range(0, 1));
      IDEX_RD       = 3'($urandom_range(0, 4));
      EXMEM_RegWrt  = 1'($urandom_range(0, 1));
      EXMEM_RD      = 3'($urandom_range(0, 4));
      misprediction = ($urandom_range(0, 9) == 0);
      if (burst > 0) begin
        DM_Req = 1; Done_DM = 0; burst--;
      end else if ($urandom_range(0, 14) == 0) begin
        DM_Req = 1; Done_DM = 0; burst = $urandom_range(1, 8);
      end else begin
        DM_Req  = ($urandom_range(0, 3) == 0);
        Done_DM = 1'($urandom_range(0, 1));
      end
      step();
    end

    @(negedge clk);
    #1;
    run_active = 0;
    n_cmp++;
    if (qa.size() + qb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain got=%0d entries exp=0", qa.size() + qb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
